fu_issue_buffer: RTL

Multi-lane in-order FIFO between the reservation-station issue/select logic and the FU packet inputs of one functional-unit class (ALU, MULT, LOAD or STORE). Each cycle it accepts up to NUM_IN issued packets and holds them in issue order. It hands the oldest ones to whichever FU lanes report available. Its registered free-slot count is the RS's issue budget for the next cycle, and it flushes on squash.

---
 rtl/fu_issue_buffer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fu_issue_buffer.sv
// ---------------------------------------------------------------------------
// fu_issue_buffer
//
// A multi-lane in-order FIFO. It sits between the reservation-station
// issue/select logic and the packet inputs of one functional-unit class.
//
// Each cycle the buffer:
//   - accepts up to NUM_IN issued packets, compacted in lane order,
//   - hands the oldest held packets to the FU lanes that report available,
//   - publishes a registered free-slot count, which the RS uses as its
//     issue budget for the following cycle.
//
// A squash flushes all queued packets but keeps the sticky overflow flag.
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-low; clears all state including entries
//   squash      synchronous flush (active-high), out_valid held low meanwhile
//   in_valid    per issue lane: lane carries a packet (lane 0 oldest)
//   in_packet   per issue lane: opaque FU packet
//   fu_avail    per FU lane: lane can take a packet this cycle
//   out_valid   per FU lane: packet presented (consumed the same cycle)
//   out_packet  per FU lane: packet, zero when out_valid is low
//   free_slots  DEPTH - count, registered
//   count       occupied entries, registered
//   overflow    sticky, set when an issued packet had to be dropped
// ---------------------------------------------------------------------------
module fu_issue_buffer #(
  parameter int NUM_IN = 3,
  parameter int NUM_FU = 2,
  parameter int DEPTH  = 8,
  parameter int PKT_W  = 64,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             squash,
  input  logic [NUM_IN-1:0]                in_valid,
  input  logic [NUM_IN-1:0][PKT_W-1:0]     in_packet,
  input  logic [NUM_FU-1:0]                fu_avail,
  output logic [NUM_FU-1:0]                out_valid,
  output logic [NUM_FU-1:0][PKT_W-1:0]     out_packet,
  output logic [CNT_W-1:0]                 free_slots,
  output logic [CNT_W-1:0]                 count,
  output logic                             overflow
);

  // Pointers wrap naturally because DEPTH is a power of two.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PKT_W-1:0]              entries_q [DEPTH];
  logic [PTR_W-1:0]              head_q, head_d;
  logic [PTR_W-1:0]              tail_q, tail_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic [CNT_W-1:0]              free_q, free_d;
  logic                          overflow_q, overflow_d;

  logic [NUM_IN-1:0]             push_en;
  logic [NUM_IN-1:0][PTR_W-1:0]  push_idx;
  logic [CNT_W-1:0]              push_cnt;
  logic                          drop;
  logic [CNT_W-1:0]              pop_cnt;

  // Pop selection.
  // k counts the available FU lanes below lane i. The first count_q
  // available lanes receive consecutive entries starting at head, so a
  // lower lane always gets an older packet. Everything is driven from
  // registered state, so a packet pushed this cycle cannot bypass to the
  // outputs.
  always_comb begin
    int k;
    k          = 0;
    out_valid  = '0;
    out_packet = '0;
    pop_cnt    = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (fu_avail[i] && reset && !squash && (k < int'(count_q))) begin
        out_valid[i]  = 1'b1;
        out_packet[i] = entries_q[head_q + PTR_W'(k)];
        pop_cnt       = pop_cnt + CNT_W'(1);
      end
      if (fu_avail[i]) begin
        k = k + 1;
      end
    end
  end

  // Push compaction.
  // Valid lanes are packed in lane order. Only the space free at the
  // start of the cycle is usable, so same-cycle pops never make room.
  // Any valid lane that does not fit is dropped and flagged.
  always_comb begin
    logic [CNT_W-1:0] j;
    j        = '0;
    push_en  = '0;
    push_idx = '0;
    drop     = 1'b0;
    for (int l = 0; l < NUM_IN; l++) begin
      if (in_valid[l]) begin
        if (j < free_q) begin
          push_en[l]  = 1'b1;
          push_idx[l] = tail_q + PTR_W'(j);
          j           = j + CNT_W'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
    push_cnt = j;
  end

  // Next-state bookkeeping.
  // A squash empties the queue and discards this cycle's inputs, so a
  // drop during a squash does not raise overflow either. free_slots is
  // kept as its own register so the RS budget comes straight from a flop.
  always_comb begin
    head_d     = head_q + PTR_W'(pop_cnt);
    tail_d     = tail_q + PTR_W'(push_cnt);
    count_d    = count_q + push_cnt - pop_cnt;
    overflow_d = overflow_q | drop;
    if (squash) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      overflow_d = overflow_q;
    end
    free_d = CNT_W'(DEPTH) - count_d;
  end

  // State registers.
  // Reset has priority over squash. It also clears the entry array and
  // the sticky overflow flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      free_q     <= CNT_W'(DEPTH);
      overflow_q <= 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
        entries_q[e] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      free_q     <= free_d;
      overflow_q <= overflow_d;
      if (!squash) begin
        for (int l = 0; l < NUM_IN; l++) begin
          if (push_en[l]) begin
            entries_q[push_idx[l]] <= in_packet[l];
          end
        end
      end
    end
  end

  assign count      = count_q;
  assign free_slots = free_q;
  assign overflow   = overflow_q;

endmodule
